// File: rtl/mem_arb_pkg.sv
// Shared types and memory access-mode codes for the IF/LS memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_e;
   typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;

   localparam logic [2:0] MEM_B    = 3'b000;
   localparam logic [2:0] MEM_H    = 3'b001;
   localparam logic [2:0] MEM_W    = 3'b010;
   localparam logic [2:0] MEM_BU   = 3'b011;
   localparam logic [2:0] MEM_HU   = 3'b100;
   localparam logic [2:0] MEM_NONE = 3'b111;

endpackage

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
// LS has priority; IF is forced through after STARVE_LIM consecutive LS wins.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_kill,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic [2:0]        ls_mode,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_mode,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

   arb_state_e        state, state_nxt;
   arb_owner_e        owner;
   logic [CNT_W-1:0]  starve_cnt;
   logic              kill_flag;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        mode_q;

   logic if_wins, ls_wins;

   // A killed fetch is not eligible, so LS (or nobody) takes the slot that cycle.
   assign if_wins = if_req & ~if_kill & (~ls_req | (starve_cnt == CNT_MAX));
   assign ls_wins = ls_req & ~if_wins;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (if_wins | ls_wins) state_nxt = REQ;
         REQ:     if (mem_gnt)           state_nxt = RESP;
         RESP:    if (mem_rvalid)        state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner   <= OWN_IF;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         mode_q  <= MEM_B;
      end else if (state == IDLE) begin
         if (if_wins) begin
            owner   <= OWN_IF;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            mode_q  <= MEM_W;
         end else if (ls_wins) begin
            owner   <= OWN_LS;
            addr_q  <= ls_addr;
            we_q    <= ls_we;
            wdata_q <= ls_wdata;
            mode_q  <= ls_mode;
         end
      end
   end

   // Counts LS wins that left a waiting fetch behind; any idle cycle without a fetch resets it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (if_wins || !if_req)
            starve_cnt <= '0;
         else if (ls_wins && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          kill_flag <= 1'b0;
      else if (state == IDLE)              kill_flag <= 1'b0;
      else if (if_kill && owner == OWN_IF) kill_flag <= 1'b1;
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_mode  = MEM_B;
      if_gnt    = 1'b0;
      ls_gnt    = 1'b0;
      if_rvalid = 1'b0;
      ls_rvalid = 1'b0;
      if_rdata  = '0;
      ls_rdata  = '0;
      unique case (state)
         REQ: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_mode  = mode_q;
            if_gnt    = mem_gnt & (owner == OWN_IF);
            ls_gnt    = mem_gnt & (owner == OWN_LS);
         end
         RESP: begin
            // A kill arriving in the same cycle as the response still suppresses it.
            if_rvalid = mem_rvalid & (owner == OWN_IF) & ~kill_flag & ~if_kill;
            ls_rvalid = mem_rvalid & (owner == OWN_LS);
            if (if_rvalid) if_rdata = mem_rdata;
            if (ls_rvalid) ls_rdata = mem_rdata;
         end
         default: ;
      endcase
   end

endmodule
